// File: rtl/axi_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_tb_pkg
// Description : Shared scheduler state encoding and AXI BRESP codes.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

endpackage
`default_nettype wire

// File: rtl/axi_id_tracker.sv
`default_nettype none
// ============================================================================
// Module      : axi_id_tracker
// Description : Per-ID busy vector with set/clear ports and busy lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_id_tracker #(
    parameter int AXI_ID_W = 4
) (
    input  logic                aclk,
    input  logic                srst,
    input  logic                set_en,
    input  logic [AXI_ID_W-1:0] set_id,
    input  logic                clr_en,
    input  logic [AXI_ID_W-1:0] clr_id,
    input  logic [AXI_ID_W-1:0] lookup_id,
    output logic                lookup_busy,
    output logic                clr_busy,
    output logic                unexp_clr
);

    localparam int c_ID_NUM = 1 << AXI_ID_W;

    logic [c_ID_NUM-1:0] r_busy;

    assign lookup_busy = r_busy[lookup_id];
    assign clr_busy    = r_busy[clr_id];
    assign unexp_clr   = clr_en && !r_busy[clr_id];

    // Set and clear never target the same ID in one cycle: a busy ID cannot be accepted.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_busy <= '0;
        end else begin
            if (clr_en && r_busy[clr_id]) begin
                r_busy[clr_id] <= 1'b0;
            end
            if (set_en) begin
                r_busy[set_id] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_wr_sched.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_sched
// Description : AXI write-command scheduler with per-ID ordering and B tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_sched
    import axi_tb_pkg::*;
#(
    parameter int AXI_ADDR_W      = 32,
    parameter int AXI_ID_W        = 4,
    parameter int MST_OSTDREQ_NUM = 4
) (
    input  logic                              aclk,
    input  logic                              srst,
    input  logic                              en,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [AXI_ADDR_W-1:0]             cmd_addr,
    input  logic [7:0]                        cmd_len,
    input  logic [AXI_ID_W-1:0]               cmd_id,
    output logic                              awvalid,
    input  logic                              awready,
    output logic [AXI_ADDR_W-1:0]             awaddr,
    output logic [7:0]                        awlen,
    output logic [AXI_ID_W-1:0]               awid,
    input  logic                              bvalid,
    output logic                              bready,
    input  logic [AXI_ID_W-1:0]               bid,
    input  logic [1:0]                        bresp,
    output logic [$clog2(MST_OSTDREQ_NUM):0]  ost_cnt,
    output logic                              idle,
    output logic                              err_unexp_b,
    output logic [7:0]                        err_resp_cnt
);

    localparam int                 c_CNT_W   = $clog2(MST_OSTDREQ_NUM) + 1;
    localparam logic [c_CNT_W-1:0] c_OST_MAX = c_CNT_W'(MST_OSTDREQ_NUM);

    state_t                  r_state;
    logic                    r_awvalid;
    logic [AXI_ADDR_W-1:0]   r_awaddr;
    logic [7:0]              r_awlen;
    logic [AXI_ID_W-1:0]     r_awid;
    logic [c_CNT_W-1:0]      r_ost;
    logic                    r_unexp;
    logic [7:0]              r_err_cnt;

    logic w_cmd_busy;
    logic w_b_busy;
    logic w_b_unexp;
    logic w_cmd_ready;
    logic w_cmd_acc;
    logic w_b_hs;
    logic w_b_ok;

    axi_id_tracker #(
        .AXI_ID_W (AXI_ID_W)
    ) u_id_tracker (
        .aclk        (aclk),
        .srst        (srst),
        .set_en      (w_cmd_acc),
        .set_id      (cmd_id),
        .clr_en      (w_b_hs),
        .clr_id      (bid),
        .lookup_id   (cmd_id),
        .lookup_busy (w_cmd_busy),
        .clr_busy    (w_b_busy),
        .unexp_clr   (w_b_unexp)
    );

    assign w_cmd_ready = (r_state == RUN) && (!r_awvalid || awready) &&
                         (r_ost < c_OST_MAX) && !w_cmd_busy;
    assign w_cmd_acc   = cmd_valid && w_cmd_ready;
    assign w_b_hs      = bvalid && bready;
    assign w_b_ok      = w_b_hs && w_b_busy;

    assign cmd_ready    = w_cmd_ready;
    assign awvalid      = r_awvalid;
    assign awaddr       = r_awaddr;
    assign awlen        = r_awlen;
    assign awid         = r_awid;
    assign bready       = (r_ost != '0);
    assign ost_cnt      = r_ost;
    assign idle         = (r_state == IDLE) && (r_ost == '0);
    assign err_unexp_b  = r_unexp;
    assign err_resp_cnt = r_err_cnt;

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state   <= IDLE;
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awid    <= '0;
            r_ost     <= '0;
            r_unexp   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                IDLE:    if (en) r_state <= RUN;
                RUN:     if (!en) r_state <= DRAIN;
                DRAIN: begin
                    if (en) begin
                        r_state <= RUN;
                    end else if ((r_ost == '0) && !r_awvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new accept may overwrite the payload in the same cycle the old AW handshakes.
            if (w_cmd_acc) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= cmd_addr;
                r_awlen   <= cmd_len;
                r_awid    <= cmd_id;
            end else if (awready) begin
                r_awvalid <= 1'b0;
            end

            case ({w_cmd_acc, w_b_ok})
                2'b10:   r_ost <= r_ost + c_CNT_W'(1);
                2'b01:   r_ost <= r_ost - c_CNT_W'(1);
                default: r_ost <= r_ost;
            endcase

            if (w_b_unexp) begin
                r_unexp <= 1'b1;
            end
            if (w_b_hs && (bresp != c_resp_okay) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_wr_sched
// Description : Self-checking bench for axi_wr_sched against a set-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_sched;

    localparam int AW  = 32;
    localparam int IW  = 4;
    localparam int N   = 4;
    localparam int NID = 16;
    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_DRAIN = 2;

    logic          aclk = 1'b0;
    logic          srst = 1'b1;
    logic          en = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [IW-1:0] cmd_id = '0;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [IW-1:0] awid;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [IW-1:0] bid = '0;
    logic [1:0]    bresp = '0;
    logic [2:0]    ost_cnt;
    logic          idle;
    logic          err_unexp_b;
    logic [7:0]    err_resp_cnt;

    axi_wr_sched #(
        .AXI_ADDR_W      (AW),
        .AXI_ID_W        (IW),
        .MST_OSTDREQ_NUM (N)
    ) dut (
        .aclk         (aclk),
        .srst         (srst),
        .en           (en),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_id       (cmd_id),
        .awvalid      (awvalid),
        .awready      (awready),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .awid         (awid),
        .bvalid       (bvalid),
        .bready       (bready),
        .bid          (bid),
        .bresp        (bresp),
        .ost_cnt      (ost_cnt),
        .idle         (idle),
        .err_unexp_b  (err_unexp_b),
        .err_resp_cnt (err_resp_cnt)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    int dut_aw_hs = 0;

    always @(posedge aclk) if (!srst && awvalid && awready) dut_aw_hs <= dut_aw_hs + 1;

    // Reference model: set of busy IDs, FIFO of issued-but-unsent AWs, mode, error tallies.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } aw_t;

    aw_t m_aw[$];
    bit  m_busy[NID];
    int  m_mode = MD_IDLE;
    bit  m_unexp = 1'b0;
    int  m_rerr = 0;
    bit  m_acc = 1'b0;

    function automatic int busy_cnt();
        int c = 0;
        for (int i = 0; i < NID; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_aw.delete();
        for (int i = 0; i < NID; i++) m_busy[i] = 1'b0;
        m_mode  = MD_IDLE;
        m_unexp = 1'b0;
        m_rerr  = 0;
    endtask

    // One clock: check outputs against the model, clock, then advance the model.
    task automatic cyc();
        int  cnt;
        bit  awv, rdy, awhs, bhs;
        aw_t e;
        #1;
        cnt = busy_cnt();
        awv = (m_aw.size() != 0);
        rdy = (m_mode == MD_RUN) && (!awv || awready) && (cnt < N) && !m_busy[cmd_id];
        chk("cmd_ready", cmd_ready, rdy);
        chk("awvalid", awvalid, awv);
        if (awv) begin
            chk("awaddr", awaddr, m_aw[0].addr);
            chk("awlen", awlen, m_aw[0].len);
            chk("awid", awid, m_aw[0].id);
        end
        chk("ost_cnt", ost_cnt, cnt);
        chk("bready", bready, cnt != 0);
        chk("idle", idle, (m_mode == MD_IDLE) && (cnt == 0));
        chk("err_unexp_b", err_unexp_b, m_unexp);
        chk("err_resp_cnt", err_resp_cnt, m_rerr);
        m_acc = cmd_valid && rdy && !srst;
        awhs  = awv && awready;
        bhs   = bvalid && (cnt != 0);
        @(posedge aclk);
        if (srst) begin
            model_reset();
        end else begin
            if (awhs) void'(m_aw.pop_front());
            if (bhs) begin
                if (m_busy[bid]) m_busy[bid] = 1'b0;
                else m_unexp = 1'b1;
                if (bresp != 2'b00 && m_rerr < 255) m_rerr++;
            end
            if (m_acc) begin
                e.addr = cmd_addr; e.len = cmd_len; e.id = cmd_id;
                m_aw.push_back(e);
                m_busy[cmd_id] = 1'b1;
            end
            case (m_mode)
                MD_IDLE:  if (en) m_mode = MD_RUN;
                MD_RUN:   if (!en) m_mode = MD_DRAIN;
                default:  if (en) m_mode = MD_RUN;
                          else if (cnt == 0 && !awv) m_mode = MD_IDLE;
            endcase
        end
        @(negedge aclk);
    endtask

    task automatic do_reset();
        srst = 1'b1; en = 1'b0; cmd_valid = 1'b0; bvalid = 1'b0; awready = 1'b0;
        cyc();
        srst = 1'b0;
    endtask

    task automatic send_cmd(input int id, input logic [AW-1:0] a, input logic [7:0] l,
                            input int bound, output bit ok);
        cmd_valid = 1'b1; cmd_id = IW'(id); cmd_addr = a; cmd_len = l; ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            cyc();
            ok = m_acc;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_exp(input int id, input logic [AW-1:0] a, input logic [7:0] l);
        bit ok;
        send_cmd(id, a, l, 20, ok);
        chk($sformatf("accept_id%0d", id), ok, 1);
    endtask

    task automatic send_b(input int id, input logic [1:0] r);
        bvalid = 1'b1; bid = IW'(id); bresp = r;
        cyc();
        bvalid = 1'b0;
    endtask

    initial begin
        bit ok;
        int base;
        int pick[$];
        @(negedge aclk);

        // Reset state
        do_reset();
        #1;
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_awid", awid, 0);
        chk("rst_idle", idle, 1);

        // Outstanding limit, then a B frees room for the fifth write
        do_reset();
        en = 1'b1; awready = 1'b1;
        cyc();
        base = dut_aw_hs;
        for (int k = 0; k < 4; k++) send_exp(k, AW'(32'h1000 + k * 16), 8'(k));
        send_cmd(4, 32'h1040, 8'd4, 5, ok);
        chk("lim_5th_blocked", ok, 0);
        chk("lim_ost", ost_cnt, 4);
        chk("lim_aw_hs", dut_aw_hs - base, 4);
        bvalid = 1'b1; bid = 4'd0; bresp = 2'b00;
        cyc();
        bvalid = 1'b0;
        send_exp(4, 32'h1040, 8'd4);
        cyc();
        chk("lim_aw_hs5", dut_aw_hs - base, 5);

        // Same-ID ordering
        do_reset();
        en = 1'b1; awready = 1'b1;
        cyc();
        send_exp(3, 32'h2000, 8'd1);
        cmd_valid = 1'b1; cmd_id = 4'd3; cmd_addr = 32'h2010;
        repeat (4) begin
            #1 chk("sameid_hold", cmd_ready, 0);
            cyc();
        end
        bvalid = 1'b1; bid = 4'd3; bresp = 2'b00;
        #1 chk("sameid_b_cycle", cmd_ready, 0);
        cyc();
        bvalid = 1'b0;
        #1 chk("sameid_free", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;

        // AW held under backpressure across en drop, then drain to IDLE
        do_reset();
        en = 1'b1; awready = 1'b0;
        cyc();
        send_exp(5, 32'hDEAD_BEE0, 8'd200);
        en = 1'b0;
        repeat (10) begin
            cyc();
            chk("bp_awvalid", awvalid, 1);
            chk("bp_awaddr", awaddr, 32'hDEAD_BEE0);
            chk("bp_awlen", awlen, 200);
            chk("bp_awid", awid, 5);
        end
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        send_b(5, 2'b00);
        repeat (3) cyc();
        chk("bp_idle", idle, 1);

        // Accept and B on different IDs in the same cycle
        do_reset();
        en = 1'b1; awready = 1'b1;
        cyc();
        send_exp(2, 32'h3000, 8'd0);
        send_exp(3, 32'h3010, 8'd0);
        cmd_valid = 1'b1; cmd_id = 4'd1; cmd_addr = 32'h3020;
        bvalid = 1'b1; bid = 4'd2; bresp = 2'b00;
        #1 chk("same_cyc_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0; bvalid = 1'b0;
        #1 chk("same_cyc_ost", ost_cnt, 2);
        cmd_id = 4'd1;
        #1 chk("same_cyc_busy1", cmd_ready, 0);
        cmd_id = 4'd2;
        #1 chk("same_cyc_free2", cmd_ready, 1);
        cyc();

        // Unexpected B and saturating error-response count
        do_reset();
        en = 1'b1; awready = 1'b1;
        cyc();
        send_exp(0, 32'h4000, 8'd0);
        send_b(7, 2'b00);
        chk("unexp_flag", err_unexp_b, 1);
        send_b(0, 2'b10);
        for (int i = 1; i < 300; i++) begin
            send_exp(i % NID, AW'(i), 8'(i));
            send_b(i % NID, 2'b10);
        end
        chk("sat_cnt", err_resp_cnt, 255);
        chk("sat_unexp", err_unexp_b, 1);

        // Reset in the middle of traffic
        do_reset();
        en = 1'b1; awready = 1'b1;
        cyc();
        send_exp(0, 32'h5000, 8'd0);
        send_exp(1, 32'h5010, 8'd0);
        send_exp(2, 32'h5020, 8'd0);
        awready = 1'b0;
        cyc();
        chk("mid_ost", ost_cnt, 3);
        chk("mid_awvalid", awvalid, 1);
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        #1;
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_ost", ost_cnt, 0);
        chk("mid_rst_idle", idle, 1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 7) != 0);
            cmd_valid = $urandom_range(0, 1) != 0;
            cmd_id    = IW'($urandom_range(0, NID - 1));
            cmd_addr  = AW'($urandom);
            cmd_len   = 8'($urandom);
            awready   = $urandom_range(0, 2) != 0;
            bvalid    = $urandom_range(0, 1) != 0;
            bresp     = 2'($urandom);
            pick.delete();
            for (int i = 0; i < NID; i++) if (m_busy[i]) pick.push_back(i);
            if (pick.size() != 0 && $urandom_range(0, 3) != 0)
                bid = IW'(pick[$urandom_range(0, pick.size() - 1)]);
            else
                bid = IW'($urandom_range(0, NID - 1));
            srst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        srst = 1'b0; cmd_valid = 1'b0; bvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
